// File: rtl/instr_mem_loader.sv
// Boot-time program loader and instruction-memory port arbiter: streams a program from UART into BRAM,
// then hands the BRAM read port to fetch. Define LOADER_ACK_EN to send an 8'hAA ack before release.
module instr_mem_loader #(
  parameter int ADDR_W = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  input  logic [15:0]       fetch_addr,
  output logic [31:0]       fetch_instr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              core_reset,
  output logic              load_error,
  output logic [15:0]       words_loaded
);

`ifdef LOADER_ACK_EN
  typedef enum logic [2:0] {ST_HDR, ST_LOAD, ST_ACK, ST_DONE, ST_ERR} state_e;
  localparam state_e ST_FINISH = ST_ACK;
`else
  typedef enum logic [2:0] {ST_HDR, ST_LOAD, ST_DONE, ST_ERR} state_e;
  localparam state_e ST_FINISH = ST_DONE;
`endif

  // Largest legal word count; a header above this is rejected.
  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       word_q, word_d;
  logic              wr_pend_q, wr_pend_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [15:0]       words_loaded_q, words_loaded_d;
  logic              core_reset_q;

  logic [31:0]       assembled;
  logic              byte_accept;
  logic              word_complete;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_HDR;
      byte_cnt_q     <= '0;
      shift_q        <= '0;
      word_q         <= '0;
      wr_pend_q      <= 1'b0;
      n_q            <= '0;
      words_loaded_q <= '0;
      core_reset_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      shift_q        <= shift_d;
      word_q         <= word_d;
      wr_pend_q      <= wr_pend_d;
      n_q            <= n_d;
      words_loaded_q <= words_loaded_d;
      core_reset_q   <= (state_q != ST_DONE);
    end
  end

  // Bytes are big-endian: the first byte of a word ends up in bits [31:24].
  assign assembled     = {shift_q[23:0], rx_data};
  assign byte_accept   = rx_valid && ((state_q == ST_HDR) || (state_q == ST_LOAD));
  assign word_complete = byte_accept && (byte_cnt_q == 2'd3);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    shift_d        = shift_q;
    word_d         = word_q;
    wr_pend_d      = 1'b0;
    n_d            = n_q;
    words_loaded_d = words_loaded_q;

    if (byte_accept) begin
      shift_d    = assembled;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end

    case (state_q)
      ST_HDR: begin
        if (word_complete) begin
          if (assembled == 32'd0) begin
            state_d = ST_FINISH;
          end else if (assembled > CAPACITY) begin
            state_d = ST_ERR;
          end else begin
            state_d        = ST_LOAD;
            n_d            = assembled[ADDR_W:0];
            words_loaded_d = '0;
          end
        end
      end
      ST_LOAD: begin
        if (word_complete) begin
          word_d    = assembled;
          wr_pend_d = 1'b1;
        end
        // The write happens this cycle; the count and the exit decision follow it.
        if (wr_pend_q) begin
          words_loaded_d = words_loaded_q + 16'd1;
          if (words_loaded_d == 16'(n_q)) state_d = ST_FINISH;
        end
      end
`ifdef LOADER_ACK_EN
      ST_ACK: begin
        if (tx_ready) state_d = ST_DONE;
      end
`endif
      default: ;
    endcase

    // A state change drops any partial word and any pending write.
    if (state_d != state_q) begin
      byte_cnt_d = '0;
      wr_pend_d  = 1'b0;
    end
  end

  // Until the program is in place the loader owns the BRAM port; afterwards fetch drives it directly.
  assign mem_we       = wr_pend_q;
  assign mem_wdata    = word_q;
  assign mem_addr     = (state_q == ST_DONE) ? fetch_addr[ADDR_W-1:0] : words_loaded_q[ADDR_W-1:0];
  assign fetch_instr  = (state_q == ST_DONE) ? mem_rdata : 32'd0;
  assign core_reset   = core_reset_q;
  assign load_error   = (state_q == ST_ERR);
  assign words_loaded = words_loaded_q;

`ifdef LOADER_ACK_EN
  assign tx_valid = (state_q == ST_ACK);
  assign tx_data  = 8'hAA;

  logic unused_fetch_bits;
  assign unused_fetch_bits = ^fetch_addr[15:ADDR_W];
`else
  assign tx_valid = 1'b0;
  assign tx_data  = 8'h00;

  logic unused_inputs;
  assign unused_inputs = ^{fetch_addr[15:ADDR_W], tx_ready};
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed scenarios plus randomized loads scored against
// a stream-level model of the load protocol and a behavioural BRAM.
module tb_instr_mem_loader;
  localparam int ADDR_W = 15;
  localparam int CAP    = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic [15:0]       fetch_addr;
  logic [31:0]       fetch_instr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              core_reset;
  logic              load_error;
  logic [15:0]       words_loaded;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .fetch_addr(fetch_addr), .fetch_instr(fetch_instr),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_reset(core_reset), .load_error(load_error), .words_loaded(words_loaded)
  );

  // Behavioural BRAM with one-cycle read latency.
  logic [31:0] bram [CAP];
  always @(posedge clock) begin
    if (mem_we === 1'b1) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  // Observed writes, sampled mid-cycle.
  logic [ADDR_W-1:0] act_addr[$];
  logic [31:0]       act_data[$];
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      act_addr.push_back(mem_addr);
      act_data.push_back(mem_wdata);
    end
  end

`ifndef LOADER_ACK_EN
  int tx_busy_cycles = 0;
  always @(negedge clock) begin
    if (reset === 1'b0 && (tx_valid !== 1'b0 || tx_data !== 8'h00)) tx_busy_cycles++;
  end
`endif

  // Reference model: byte stream -> expected writes.
  logic [7:0]        stim[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  bit                exp_err;
  int                exp_n;

  task automatic model();
    logic [31:0] n;
    exp_addr.delete();
    exp_data.delete();
    exp_err = 1'b0;
    exp_n   = 0;
    n = {stim[0], stim[1], stim[2], stim[3]};
    if (n > 32'(CAP)) begin
      exp_err = 1'b1;
    end else begin
      exp_n = int'(n);
      for (int i = 0; i < exp_n; i++) begin
        exp_addr.push_back(i[ADDR_W-1:0]);
        exp_data.push_back({stim[4+4*i], stim[5+4*i], stim[6+4*i], stim[7+4*i]});
      end
    end
  endtask

  task automatic build_stream(input int n, input int extra);
    logic [31:0] w;
    logic [31:0] nn;
    stim.delete();
    nn = n;
    for (int b = 3; b >= 0; b--) stim.push_back(nn[8*b +: 8]);
    for (int i = 0; i < n + extra; i++) begin
      w = $urandom;
      for (int b = 3; b >= 0; b--) stim.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_stream(input int gap_min, input int gap_max);
    foreach (stim[i]) begin
      repeat ($urandom_range(gap_max, gap_min)) step();
      send_byte(stim[i]);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    act_addr.delete();
    act_data.delete();
  endtask

  task automatic wait_release(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (core_reset === 1'b0) ok = 1'b1;
      else step();
    end
    if (core_reset === 1'b0) ok = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    fetch_addr = 16'h1234;
    #1;
    n_checks++; if (core_reset !== 1'b1) $display("FAIL reset_core_reset: got %b want 1", core_reset); else n_pass++;
    n_checks++; if (load_error !== 1'b0) $display("FAIL reset_load_error: got %b want 0", load_error); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else n_pass++;
    n_checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else n_pass++;
    n_checks++; if (words_loaded !== 16'd0) $display("FAIL reset_words_loaded: got %0d want 0", words_loaded); else n_pass++;
    n_checks++; if (fetch_instr !== 32'd0) $display("FAIL reset_fetch_instr: got %h want 0", fetch_instr); else n_pass++;
    n_checks++; if (mem_addr !== '0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
    fetch_addr = 16'h0000;
  endtask

  task automatic test_normal();
    logic [7:0] bytes [12];
    bit ok;
    bytes = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(bytes[i]);
    n_checks++; if (mem_we !== 1'b1) $display("FAIL normal_we0: got %b want 1", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== '0) $display("FAIL normal_addr0: got %h want 0", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 32'h12345678) $display("FAIL normal_data0: got %h want 12345678", mem_wdata); else n_pass++;
    send_byte(bytes[8]);
    n_checks++; if (mem_we !== 1'b0) $display("FAIL normal_we_pulse: got %b want 0", mem_we); else n_pass++;
    n_checks++; if (words_loaded !== 16'd1) $display("FAIL normal_wl1: got %0d want 1", words_loaded); else n_pass++;
    for (int i = 9; i < 12; i++) send_byte(bytes[i]);
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 15'd1 || mem_wdata !== 32'h9ABCDEF0)
      $display("FAIL normal_write1: got we=%b addr=%h data=%h want we=1 addr=1 data=9abcdef0", mem_we, mem_addr, mem_wdata);
    else n_pass++;
    n_checks++; if (core_reset !== 1'b1) $display("FAIL normal_core_held: got %b want 1", core_reset); else n_pass++;
    step();
    n_checks++; if (words_loaded !== 16'd2) $display("FAIL normal_wl2: got %0d want 2", words_loaded); else n_pass++;
    wait_release(6, ok);
    n_checks++; if (!ok) $display("FAIL normal_release: got core_reset=%b want 0", core_reset); else n_pass++;
    fetch_addr = 16'h8001;
    step();
    n_checks++; if (fetch_instr !== 32'h9ABCDEF0) $display("FAIL normal_fetch1: got %h want 9abcdef0", fetch_instr); else n_pass++;
    fetch_addr = 16'h0000;
    step();
    n_checks++; if (fetch_instr !== 32'h12345678) $display("FAIL normal_fetch0: got %h want 12345678", fetch_instr); else n_pass++;
    n_checks++; if (act_addr.size() !== 2) $display("FAIL normal_write_count: got %0d want 2", act_addr.size()); else n_pass++;
  endtask

  task automatic test_empty();
    do_reset();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    step();
    step();
    n_checks++; if (core_reset !== 1'b0) $display("FAIL empty_release: got %b want 0", core_reset); else n_pass++;
    n_checks++; if (act_addr.size() !== 0) $display("FAIL empty_writes: got %0d want 0", act_addr.size()); else n_pass++;
    n_checks++; if (words_loaded !== 16'd0) $display("FAIL empty_wl: got %0d want 0", words_loaded); else n_pass++;
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h80); send_byte(8'h01);
    n_checks++; if (load_error !== 1'b1) $display("FAIL over_error: got %b want 1", load_error); else n_pass++;
    for (int i = 0; i < 12; i++) send_byte(8'($urandom));
    repeat (3) step();
    n_checks++; if (act_addr.size() !== 0) $display("FAIL over_writes: got %0d want 0", act_addr.size()); else n_pass++;
    n_checks++; if (load_error !== 1'b1 || core_reset !== 1'b1)
      $display("FAIL over_held: got err=%b core_reset=%b want 1 1", load_error, core_reset);
    else n_pass++;
    n_checks++; if (words_loaded !== 16'd0) $display("FAIL over_wl: got %0d want 0", words_loaded); else n_pass++;
    n_checks++; if (fetch_instr !== 32'd0) $display("FAIL over_fetch: got %h want 0", fetch_instr); else n_pass++;
  endtask

  task automatic test_max_header();
    logic [31:0] w;
    w = $urandom;
    do_reset();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h80); send_byte(8'h00);
    n_checks++; if (load_error !== 1'b0) $display("FAIL max_accept: got err=%b want 0", load_error); else n_pass++;
    for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
    step();
    n_checks++; if (act_addr.size() !== 1 || act_data[0] !== w)
      $display("FAIL max_first_write: got n=%0d want 1 word %h", act_addr.size(), w);
    else n_pass++;
    n_checks++; if (words_loaded !== 16'd1 || core_reset !== 1'b1)
      $display("FAIL max_progress: got wl=%0d core_reset=%b want 1 1", words_loaded, core_reset);
    else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    do_reset();
    build_stream(3, 0);
    for (int i = 0; i < 10; i++) send_byte(stim[i]);
    n_checks++; if (words_loaded !== 16'd1 || mem_addr !== 15'd1)
      $display("FAIL mid_progress: got wl=%0d addr=%h want 1 1", words_loaded, mem_addr);
    else n_pass++;
    do_reset();
    n_checks++; if (words_loaded !== 16'd0 || core_reset !== 1'b1 || load_error !== 1'b0 || mem_we !== 1'b0)
      $display("FAIL mid_reset_state: got wl=%0d cr=%b err=%b we=%b want 0 1 0 0", words_loaded, core_reset, load_error, mem_we);
    else n_pass++;
    build_stream(1, 0);
    model();
    send_stream(0, 0);
    wait_release(10, ok);
    n_checks++; if (!ok) $display("FAIL mid_release: got core_reset=%b want 0", core_reset); else n_pass++;
    n_checks++; if (act_addr.size() !== 1 || act_addr[0] !== exp_addr[0] || act_data[0] !== exp_data[0])
      $display("FAIL mid_reload_write: got n=%0d want 1 write of %h at 0", act_addr.size(), exp_data[0]);
    else n_pass++;
  endtask

  task automatic test_gapped();
    bit ok;
    do_reset();
    build_stream(1, 0);
    model();
    send_stream(1, 3);
    wait_release(10, ok);
    n_checks++; if (!ok) $display("FAIL gap_release: got core_reset=%b want 0", core_reset); else n_pass++;
    n_checks++; if (act_addr.size() !== 1 || act_data[0] !== exp_data[0])
      $display("FAIL gap_write: got n=%0d want 1 write of %h", act_addr.size(), exp_data[0]);
    else n_pass++;
  endtask

`ifdef LOADER_ACK_EN
  task automatic test_ack();
    do_reset();
    tx_ready = 1'b0;
    build_stream(1, 0);
    send_stream(0, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hAA || core_reset !== 1'b1)
        $display("FAIL ack_hold: got v=%b d=%h cr=%b want 1 aa 1", tx_valid, tx_data, core_reset);
      else n_pass++;
      step();
    end
    tx_ready = 1'b1;
    step();
    n_checks++; if (tx_valid !== 1'b0) $display("FAIL ack_drop: got %b want 0", tx_valid); else n_pass++;
    step();
    n_checks++; if (core_reset !== 1'b0) $display("FAIL ack_release: got %b want 0", core_reset); else n_pass++;
  endtask
`endif

  task automatic test_random();
    bit ok;
    int a;
    for (int iter = 0; iter < 5; iter++) begin
      do_reset();
      build_stream($urandom_range(6, 1), 1);
      model();
      send_stream(0, $urandom_range(2, 0));
      wait_release(10, ok);
      n_checks++; if (!ok) $display("FAIL rand_release[%0d]: got core_reset=%b want 0", iter, core_reset); else n_pass++;
      n_checks++; if (act_addr.size() !== exp_addr.size())
        $display("FAIL rand_count[%0d]: got %0d want %0d", iter, act_addr.size(), exp_addr.size());
      else n_pass++;
      for (int i = 0; i < exp_addr.size() && i < act_addr.size(); i++) begin
        n_checks++; if (act_addr[i] !== exp_addr[i] || act_data[i] !== exp_data[i])
          $display("FAIL rand_write[%0d.%0d]: got %h@%h want %h@%h", iter, i, act_data[i], act_addr[i], exp_data[i], exp_addr[i]);
        else n_pass++;
      end
      n_checks++; if (words_loaded !== 16'(exp_n)) $display("FAIL rand_wl[%0d]: got %0d want %0d", iter, words_loaded, exp_n); else n_pass++;
      repeat (3) begin
        a = $urandom_range(exp_n - 1, 0);
        fetch_addr = {1'($urandom), 15'(a)};
        step();
        n_checks++; if (fetch_instr !== exp_data[a])
          $display("FAIL rand_fetch[%0d]: got %h want %h at %0d", iter, fetch_instr, exp_data[a], a);
        else n_pass++;
      end
      fetch_addr = 16'h0000;
    end
  endtask

  task automatic test_tx_idle();
`ifndef LOADER_ACK_EN
    n_checks++; if (tx_busy_cycles !== 0) $display("FAIL tx_idle: got %0d active cycles want 0", tx_busy_cycles); else n_pass++;
`endif
  endtask

  initial begin
    reset      = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    tx_ready   = 1'b1;
    fetch_addr = 16'h0000;
    test_reset();
    test_normal();
    test_empty();
    test_oversize();
    test_max_header();
    test_reset_mid_load();
    test_gapped();
`ifdef LOADER_ACK_EN
    test_ack();
`endif
    test_random();
    test_tx_idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Boot-time program loader and port arbiter for the instruction memory. After reset it receives a program over the UART byte stream, writes it word by word into the instruction BRAM, and holds the core in reset meanwhile. Once loading completes it hands the BRAM read port to instruction fetch and releases the core.

## Interface
- ADDR_W, 15: instruction word address width. Capacity is 2^ADDR_W words.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_valid  in  1  one-cycle strobe from the UART receiver
- rx_data  in  8  received byte, valid with rx_valid
- tx_valid  out  1  ack byte valid (LOADER_ACK_EN only; otherwise tied 0)
- tx_data  out  8  ack byte, constant 8'hAA
- tx_ready  in  1  UART transmitter accepts the byte
- fetch_addr  in  16  word address from instruction fetch; bits [ADDR_W-1:0] are used
- fetch_instr  out  32  instruction returned to fetch
- mem_addr  out  ADDR_W  BRAM address
- mem_we  out  1  BRAM write enable
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data, one-cycle read latency
- core_reset  out  1  reset to all core pipeline stages
- load_error  out  1  header word count exceeds capacity
- words_loaded  out  16  count of words written so far

## Operation
- States: HDR, LOAD, ACK (only with LOADER_ACK_EN), DONE, ERR.
- Byte assembly:
  - A 2-bit byte counter and a 32-bit shift register collect bytes in big-endian order; the first byte becomes bits [31:24].
  - The counter wraps 3→0 on each completed word.
  - It clears on every state change.
- HDR:
  - The first 4 bytes form N, the word count.
  - N == 0: go to DONE (or ACK).
  - N > 2^ADDR_W: go to ERR.
  - Otherwise: go to LOAD with words_loaded = 0.
- LOAD:
  - The 4th byte of each word registers the assembled word.
  - On the following cycle: mem_we = 1, mem_addr = words_loaded, mem_wdata = word. words_loaded increments in that same cycle.
  - After the write that brings words_loaded to N, go to ACK (or DONE).
- ACK:
  - tx_valid = 1 and tx_data = 8'hAA are held until tx_ready = 1 is sampled.
  - Then go to DONE.
- DONE:
  - mem_addr = fetch_addr[ADDR_W-1:0], combinational.
  - mem_we = 0.
  - fetch_instr = mem_rdata.
  - rx bytes are ignored.
- ERR:
  - load_error = 1 and core_reset = 1.
  - rx bytes are ignored. Only reset exits ERR.
- Outside DONE:
  - fetch_instr = 0.
  - mem_addr = words_loaded[ADDR_W-1:0] whenever no write is in progress.
- core_reset:
  - Registered; equal to 1 unless the state register holds DONE.
  - It deasserts on the first clock after DONE is entered.

## Timing
- Reset values: state HDR, core_reset 1, load_error 0, mem_we 0, tx_valid 0, words_loaded 0, byte counter 0, fetch_instr 0.
- Write latency:
  - rx_valid carrying byte 3 at cycle t → mem_we high at t+1 for exactly one cycle.
  - rx_valid at t+1 is accepted normally; the next word's byte 0 is not lost.
- Back-to-back rx_valid on every cycle is supported in all states.
- Reset mid-operation (HDR, LOAD, ACK or ERR):
  - The loader returns to HDR and the partial word is discarded.
  - Words already written stay in BRAM and are treated as don't-care; the next load overwrites them.
- N == 2^ADDR_W is legal. The final write goes to address 2^ADDR_W−1, and words_loaded then reads 2^ADDR_W.
- Fetch side: once in DONE, a fetch_addr driven in cycle c produces its data on fetch_instr in cycle c+1, per the BRAM latency.

## Configuration
- LOADER_ACK_EN defined:
  - The ACK state exists.
  - Entering DONE requires the host to receive 8'hAA first.
  - tx_ready is honoured.
- LOADER_ACK_EN undefined:
  - There is no ACK state; LOAD (or HDR when N == 0) goes straight to DONE.
  - tx_valid = 0 and tx_data = 0 at all times.
  - tx_ready is ignored.

## Test plan
- Normal load: send 00 00 00 02, 12 34 56 78, 9A BC DE F0 back-to-back → mem_we pulses at addr 0 (32'h12345678) and addr 1 (32'h9ABCDEF0); words_loaded = 2; core_reset falls; fetch_addr = 1 → fetch_instr = 32'h9ABCDEF0 one cycle later.
- Empty program: header 00 00 00 00 → no mem_we pulse; DONE reached, core_reset falls within 2 cycles of the 4th byte.
- Oversize: header 00 00 80 01 with ADDR_W = 15 → load_error = 1, core_reset stays 1, subsequent bytes cause no writes.
- Reset mid-load: N = 3, reset asserted after 6 payload bytes → state HDR, words_loaded = 0; a fresh N = 1 load then writes addr 0 correctly.
- Ack handshake (LOADER_ACK_EN): N = 1, hold tx_ready = 0 for 5 cycles → tx_valid = 1 and tx_data = 8'hAA held throughout, core_reset stays 1; raise tx_ready → tx_valid drops and core_reset falls the next cycle.
- Gapped input: N = 1 with idle cycles between bytes and rx_data toggling while rx_valid = 0 → the single write carries only the strobed bytes.
